// File: rtl/pipe_pkg.sv
// Shared widths, payload field layout and occupancy encoding for the pipeline stage registers.
package pipe_pkg;

   localparam int unsigned DATA_W_DEF = 128;
   localparam int unsigned PC_W_DEF   = 32;
   localparam int unsigned EXC_W_DEF  = 5;

   localparam logic [EXC_W_DEF-1:0] EXC_NONE = '0;

   // Payload layout as concatenated by the instantiating stage: {IR, RS, RT, EXT}.
   localparam int unsigned FIELD_W = 32;
   localparam int unsigned IR_LSB  = 96;
   localparam int unsigned RS_LSB  = 64;
   localparam int unsigned RT_LSB  = 32;
   localparam int unsigned EXT_LSB = 0;

   typedef enum logic [1:0] {
      OccEmpty,
      OccOne,
      OccTwo
   } occ_e;

   function automatic logic [DATA_W_DEF-1:0] pack_payload(
      input logic [FIELD_W-1:0] ir,
      input logic [FIELD_W-1:0] rs,
      input logic [FIELD_W-1:0] rt,
      input logic [FIELD_W-1:0] ext
   );
      logic [DATA_W_DEF-1:0] p;
      p = '0;
      p[IR_LSB  +: FIELD_W] = ir;
      p[RS_LSB  +: FIELD_W] = rs;
      p[RT_LSB  +: FIELD_W] = rt;
      p[EXT_LSB +: FIELD_W] = ext;
      return p;
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage entry: valid + pc + payload + exception code with clear/load/hold control.
// Clear drops valid and zeroes payload/exc but keeps the PC so bubbles still carry an EPC.
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned EXC_W  = EXC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [PC_W-1:0]   ld_pc,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [EXC_W-1:0]  ld_exc,
   output logic              valid,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] data,
   output logic [EXC_W-1:0]  exc
);

   logic              valid_q, valid_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [EXC_W-1:0]  exc_q, exc_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      data_d  = data_q;
      exc_d   = exc_q;
      if (clear) begin
         valid_d = 1'b0;
         data_d  = '0;
         exc_d   = EXC_W'(EXC_NONE);
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = ld_pc;
         data_d  = ld_data;
         exc_d   = ld_exc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         data_q  <= '0;
         exc_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
         exc_q   <= exc_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign data  = data_q;
   assign exc   = exc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid, flush/int_flush and a
// saturating stall counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned EXC_W  = EXC_W_DEF,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              int_flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [EXC_W-1:0]  in_exc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [EXC_W-1:0]  out_exc,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              flush_any, accept, deliver, stall;
   occ_e              occ;

   logic              main_valid, main_clear, main_load;
   logic [PC_W-1:0]   main_pc, main_ld_pc;
   logic [DATA_W-1:0] main_data, main_ld_data;
   logic [EXC_W-1:0]  main_exc, main_ld_exc;

   logic              skid_valid, skid_clear, skid_load;
   logic [PC_W-1:0]   skid_pc;
   logic [DATA_W-1:0] skid_data;
   logic [EXC_W-1:0]  skid_exc;

   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign flush_any = flush | int_flush;

   always_comb begin
      occ = OccEmpty;
      if (skid_valid) begin
         occ = OccTwo;
      end else if (main_valid) begin
         occ = OccOne;
      end
   end

   // With a skid, in_ready depends only on flop state; without, it looks through to out_ready.
   always_comb begin
      if (SKID != 0) begin
         in_ready = (occ != OccTwo);
      end else begin
         in_ready = (occ == OccEmpty) | out_ready;
      end
   end

   assign accept  = in_valid & in_ready & ~flush_any;
   assign deliver = main_valid & out_ready;
   assign stall   = main_valid & ~out_ready;

   always_comb begin
      main_clear   = 1'b0;
      main_load    = 1'b0;
      main_ld_pc   = in_pc;
      main_ld_data = in_data;
      main_ld_exc  = in_exc;
      if (flush_any) begin
         main_clear = 1'b1;
      end else if (deliver) begin
         if (skid_valid) begin
            main_load    = 1'b1;
            main_ld_pc   = skid_pc;
            main_ld_data = skid_data;
            main_ld_exc  = skid_exc;
         end else if (accept) begin
            main_load = 1'b1;
         end else begin
            main_clear = 1'b1;
         end
      end else if (!main_valid && accept) begin
         main_load = 1'b1;
      end
   end

   assign skid_clear = flush_any | (deliver & skid_valid);
   assign skid_load  = (SKID != 0) & accept & main_valid & ~deliver;

   pipe_entry_reg #(
      .DATA_W (DATA_W),
      .PC_W   (PC_W),
      .EXC_W  (EXC_W)
   ) u_main (
      .clk     (clk),
      .reset   (reset),
      .clear   (main_clear),
      .load    (main_load),
      .ld_pc   (main_ld_pc),
      .ld_data (main_ld_data),
      .ld_exc  (main_ld_exc),
      .valid   (main_valid),
      .pc      (main_pc),
      .data    (main_data),
      .exc     (main_exc)
   );

   if (SKID != 0) begin : g_skid
      pipe_entry_reg #(
         .DATA_W (DATA_W),
         .PC_W   (PC_W),
         .EXC_W  (EXC_W)
      ) u_skid (
         .clk     (clk),
         .reset   (reset),
         .clear   (skid_clear),
         .load    (skid_load),
         .ld_pc   (in_pc),
         .ld_data (in_data),
         .ld_exc  (in_exc),
         .valid   (skid_valid),
         .pc      (skid_pc),
         .data    (skid_data),
         .exc     (skid_exc)
      );
   end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_pc    = '0;
      assign skid_data  = '0;
      assign skid_exc   = '0;
   end

   // int_flush wins over a coincident stall increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (int_flush) begin
         stall_cnt_d = '0;
      end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = main_valid;
   assign out_pc    = main_pc;
   assign out_data  = main_data;
   assign out_exc   = main_exc;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: u_skid (SKID=1, CNT_W=16) and u_flat (SKID=0, CNT_W=4) share all inputs.
module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         reset, flush, int_flush, in_valid, out_ready;
   logic [31:0]  in_pc;
   logic [127:0] in_data;
   logic [4:0]   in_exc;

   logic         s_in_ready, s_out_valid;
   logic [31:0]  s_out_pc;
   logic [127:0] s_out_data;
   logic [4:0]   s_out_exc;
   logic [15:0]  s_stall_cnt;

   logic         f_in_ready, f_out_valid;
   logic [31:0]  f_out_pc;
   logic [127:0] f_out_data;
   logic [4:0]   f_out_exc;
   logic [3:0]   f_stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.SKID(1), .CNT_W(16)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .int_flush (int_flush),
      .in_valid  (in_valid),
      .in_ready  (s_in_ready),
      .in_pc     (in_pc),
      .in_data   (in_data),
      .in_exc    (in_exc),
      .out_valid (s_out_valid),
      .out_ready (out_ready),
      .out_pc    (s_out_pc),
      .out_data  (s_out_data),
      .out_exc   (s_out_exc),
      .stall_cnt (s_stall_cnt)
   );

   pipe_stage_reg #(.SKID(0), .CNT_W(4)) u_flat (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .int_flush (int_flush),
      .in_valid  (in_valid),
      .in_ready  (f_in_ready),
      .in_pc     (in_pc),
      .in_data   (in_data),
      .in_exc    (in_exc),
      .out_valid (f_out_valid),
      .out_ready (out_ready),
      .out_pc    (f_out_pc),
      .out_data  (f_out_data),
      .out_exc   (f_out_exc),
      .stall_cnt (f_stall_cnt)
   );

   typedef struct {
      logic         rst, fl, ifl, iv, ord;
      logic [31:0]  pc;
      logic [127:0] data;
      logic [4:0]   exc;
      logic         chk;
      logic         ov, ir;
      logic [31:0]  opc;
      logic [127:0] od;
      logic [4:0]   oe;
      logic [15:0]  sc;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs[NVEC];

   localparam logic [127:0] D1 = {4{32'hA5A5A5A5}};
   localparam logic [127:0] DA = 128'h1111_0000_0000_000A;
   localparam logic [127:0] DB = 128'h2222_0000_0000_000B;
   localparam logic [127:0] DC = 128'h3333_0000_0000_000C;
   localparam logic [127:0] DE = 128'h4444_0000_0000_000E;
   localparam logic [127:0] DF = 128'h5555_0000_0000_000F;

   function automatic vec_t mk(
      input logic rst, input logic fl, input logic ifl, input logic iv, input logic ord,
      input logic [31:0] pc, input logic [127:0] data, input logic [4:0] exc,
      input logic chk, input logic ov, input logic ir, input logic [31:0] opc,
      input logic [127:0] od, input logic [4:0] oe, input logic [15:0] sc
   );
      vec_t v;
      v.rst = rst; v.fl = fl; v.ifl = ifl; v.iv = iv; v.ord = ord;
      v.pc = pc; v.data = data; v.exc = exc;
      v.chk = chk; v.ov = ov; v.ir = ir; v.opc = opc; v.od = od; v.oe = oe; v.sc = sc;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic ifl, input logic iv,
                        input logic ord, input logic [31:0] pc, input logic [127:0] data,
                        input logic [4:0] exc);
      reset = rst; flush = fl; int_flush = ifl; in_valid = iv; out_ready = ord;
      in_pc = pc; in_data = data; in_exc = exc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] prev_pc;
      logic [4:0]  prev_exc;

      // Each row: inputs held for one cycle; expectations are the outputs seen before its edge.
      //                rst fl ifl iv ord pc          data exc  chk ov ir opc         od  oe sc
      vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,    '0, 5'd0, 0, 0, 0, 32'h0,    '0, 5'd0, 16'd0);
      vecs[1]  = mk(0, 0, 0, 1, 1, 32'h3008, D1, 5'd0, 1, 0, 1, 32'h0,    '0, 5'd0, 16'd0);
      vecs[2]  = mk(0, 0, 0, 0, 1, 32'h0,    '0, 5'd0, 1, 1, 1, 32'h3008, D1, 5'd0, 16'd0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,    '0, 5'd0, 1, 0, 1, 32'h3008, '0, 5'd0, 16'd0);
      vecs[4]  = mk(0, 0, 0, 1, 0, 32'h100,  DA, 5'd1, 1, 0, 1, 32'h3008, '0, 5'd0, 16'd0);
      vecs[5]  = mk(0, 0, 0, 1, 0, 32'h104,  DB, 5'd2, 1, 1, 1, 32'h100,  DA, 5'd1, 16'd0);
      vecs[6]  = mk(0, 0, 0, 1, 0, 32'h108,  DC, 5'd3, 1, 1, 0, 32'h100,  DA, 5'd1, 16'd1);
      vecs[7]  = mk(0, 0, 0, 1, 0, 32'h108,  DC, 5'd3, 1, 1, 0, 32'h100,  DA, 5'd1, 16'd2);
      vecs[8]  = mk(0, 0, 0, 1, 1, 32'h108,  DC, 5'd3, 1, 1, 0, 32'h100,  DA, 5'd1, 16'd3);
      vecs[9]  = mk(0, 0, 0, 1, 1, 32'h108,  DC, 5'd3, 1, 1, 1, 32'h104,  DB, 5'd2, 16'd3);
      vecs[10] = mk(0, 0, 0, 0, 1, 32'h0,    '0, 5'd0, 1, 1, 1, 32'h108,  DC, 5'd3, 16'd3);
      vecs[11] = mk(0, 0, 0, 0, 0, 32'h0,    '0, 5'd0, 1, 0, 1, 32'h108,  '0, 5'd0, 16'd3);
      vecs[12] = mk(0, 0, 0, 1, 0, 32'h3010, DE, 5'd0, 1, 0, 1, 32'h108,  '0, 5'd0, 16'd3);
      vecs[13] = mk(0, 1, 0, 1, 0, 32'h3020, DF, 5'd7, 1, 1, 1, 32'h3010, DE, 5'd0, 16'd3);
      vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,    '0, 5'd0, 1, 0, 1, 32'h3010, '0, 5'd0, 16'd4);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].fl, vecs[i].ifl, vecs[i].iv, vecs[i].ord,
               vecs[i].pc, vecs[i].data, vecs[i].exc);
         #2;
         if (vecs[i].chk) begin
            check($sformatf("v%0d out_valid", i), s_out_valid, vecs[i].ov);
            check($sformatf("v%0d in_ready", i), s_in_ready, vecs[i].ir);
            check($sformatf("v%0d out_pc", i), s_out_pc, vecs[i].opc);
            check($sformatf("v%0d out_data", i), s_out_data, vecs[i].od);
            check($sformatf("v%0d out_exc", i), s_out_exc, vecs[i].oe);
            check($sformatf("v%0d stall_cnt", i), s_stall_cnt, vecs[i].sc);
         end
         tick();
      end

      // Counter to 37 via stalls, flush keeps it, int_flush clears it.
      drive(0, 0, 0, 1, 0, 32'h200, DA, 5'd0);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0, '0, 5'd0);
      repeat (33) tick();
      check("stall_cnt at 37", s_stall_cnt, 16'd37);
      drive(0, 1, 0, 0, 1, 32'h0, '0, 5'd0);
      tick();
      check("flush keeps stall_cnt", s_stall_cnt, 16'd37);
      check("flush out_valid", s_out_valid, 1'b0);
      check("flush keeps out_pc", s_out_pc, 32'h200);
      drive(0, 0, 1, 0, 0, 32'h0, '0, 5'd0);
      tick();
      check("int_flush clears stall_cnt", s_stall_cnt, 16'd0);

      // int_flush landing on a stall cycle still yields zero.
      drive(0, 0, 0, 1, 0, 32'h300, DB, 5'd0);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0, '0, 5'd0);
      repeat (3) tick();
      check("stall_cnt before int_flush", s_stall_cnt, 16'd3);
      drive(0, 0, 1, 0, 0, 32'h0, '0, 5'd0);
      tick();
      check("int_flush on stall", s_stall_cnt, 16'd0);
      check("int_flush out_valid", s_out_valid, 1'b0);

      // Reset while the skid stage is full discards both entries.
      drive(0, 0, 0, 1, 0, 32'h400, DC, 5'd4);
      tick();
      drive(0, 0, 0, 1, 0, 32'h404, DE, 5'd5);
      tick();
      #2;
      check("full in_ready", s_in_ready, 1'b0);
      drive(1, 0, 0, 0, 0, 32'h0, '0, 5'd0);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0, '0, 5'd0);
      #2;
      check("mid-stall reset out_valid", s_out_valid, 1'b0);
      check("mid-stall reset in_ready", s_in_ready, 1'b1);
      check("mid-stall reset out_pc", s_out_pc, 32'h0);
      check("mid-stall reset out_data", s_out_data, 128'h0);
      check("mid-stall reset flat in_ready", f_in_ready, 1'b1);

      // 4-bit counter on the flat instance saturates at 15.
      drive(0, 0, 0, 1, 0, 32'h500, DA, 5'd0);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0, '0, 5'd0);
      repeat (14) tick();
      check("flat stall_cnt 14", f_stall_cnt, 4'd14);
      repeat (6) tick();
      check("flat stall_cnt saturated", f_stall_cnt, 4'd15);
      check("flat stall in_ready", f_in_ready, 1'b0);

      // Flat streaming: one entry per cycle, in_ready held high.
      drive(1, 0, 0, 0, 0, 32'h0, '0, 5'd0);
      tick();
      prev_pc  = '0;
      prev_exc = '0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 1, 1, 32'h600 + 32'(8 * i), 128'(i + 1), (i == 2) ? 5'd12 : 5'd0);
         #2;
         check($sformatf("stream%0d in_ready", i), f_in_ready, 1'b1);
         if (i > 0) begin
            check($sformatf("stream%0d out_pc", i), f_out_pc, prev_pc);
            check($sformatf("stream%0d out_exc", i), f_out_exc, prev_exc);
            check($sformatf("stream%0d out_data", i), f_out_data, 128'(i));
         end
         prev_pc  = in_pc;
         prev_exc = in_exc;
         tick();
      end
      drive(0, 0, 0, 1, 0, 32'h700, DF, 5'd0);
      #1;
      check("flat in_ready blocked", f_in_ready, 1'b0);
      out_ready = 1'b1;
      #1;
      check("flat in_ready pass-through", f_in_ready, 1'b1);
      check("flat last out_pc", f_out_pc, 32'h628);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
